// File: rtl/priority_mux_pipe.sv
// priority_mux_pipe
//   Two-stage pipelined N-channel priority multiplexer. Stage 1 picks a winner
//   inside each GROUP-wide slice of the select vector. Stage 2 picks the winning
//   group and rebuilds the global channel index. Both stages use a valid/ready
//   handshake, so a stage-1 bubble can be filled while the output is stalled.
//
//   Ports
//     clk, rst     clock, synchronous active-high reset
//     in_valid     input transaction present
//     in_ready     block accepts input this cycle (combinational, no in_valid path)
//     sel[N]       per-channel select
//     dat[N*DW]    channel i at [i*DATA_W +: DATA_W]
//     out_valid    result present
//     out_ready    downstream accepts result
//     out_dat      winning channel data (0 when no hit)
//     out_idx      winning channel index (0 when no hit)
//     out_hit      at least one select bit was set

// Per-group priority picker. Unselected channels contribute nothing, so their
// data can never leak into the result.
module priority_mux_grp #(
    parameter int GROUP      = 6,
    parameter int DATA_W     = 8,
    parameter int HIGH_FIRST = 1,
    parameter int LIDX_W     = 3
) (
    input  logic [GROUP-1:0]        sel,
    input  logic [GROUP*DATA_W-1:0] dat,
    output logic [DATA_W-1:0]       win_dat,
    output logic [LIDX_W-1:0]       win_idx,
    output logic                    win_any
);
    // Scan from lowest to highest priority; the last hit overwrites earlier ones.
    always_comb begin
        win_dat = '0;
        win_idx = '0;
        win_any = 1'b0;
        if (HIGH_FIRST != 0) begin
            for (int j = 0; j < GROUP; j++) begin
                if (sel[j]) begin
                    win_dat = dat[j*DATA_W +: DATA_W];
                    win_idx = LIDX_W'(j);
                    win_any = 1'b1;
                end
            end
        end else begin
            for (int j = GROUP - 1; j >= 0; j--) begin
                if (sel[j]) begin
                    win_dat = dat[j*DATA_W +: DATA_W];
                    win_idx = LIDX_W'(j);
                    win_any = 1'b1;
                end
            end
        end
    end
endmodule

module priority_mux_pipe #(
    parameter  int N          = 24,
    parameter  int DATA_W     = 8,
    parameter  int GROUP      = 6,
    parameter  int HIGH_FIRST = 1,
    localparam int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          sel,
    input  logic [N*DATA_W-1:0]   dat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_dat,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_hit
);
    localparam int NGRP   = (N + GROUP - 1) / GROUP;
    localparam int NP     = NGRP * GROUP;
    localparam int LIDX_W = (GROUP > 1) ? $clog2(GROUP) : 1;

    // Padding channels carry sel=0, so they can never win.
    logic [NP-1:0]        sel_pad;
    logic [NP*DATA_W-1:0] dat_pad;

    always_comb begin
        sel_pad                 = '0;
        sel_pad[N-1:0]          = sel;
        dat_pad                 = '0;
        dat_pad[N*DATA_W-1:0]   = dat;
    end

    logic [NGRP-1:0][DATA_W-1:0] g_dat;
    logic [NGRP-1:0][LIDX_W-1:0] g_lidx;
    logic [NGRP-1:0]             g_any;

    for (genvar g = 0; g < NGRP; g++) begin : gen_grp
        priority_mux_grp #(
            .GROUP      (GROUP),
            .DATA_W     (DATA_W),
            .HIGH_FIRST (HIGH_FIRST),
            .LIDX_W     (LIDX_W)
        ) u_grp (
            .sel     (sel_pad[g*GROUP +: GROUP]),
            .dat     (dat_pad[g*GROUP*DATA_W +: GROUP*DATA_W]),
            .win_dat (g_dat[g]),
            .win_idx (g_lidx[g]),
            .win_any (g_any[g])
        );
    end

    // Pipeline state
    logic                        s1_valid_q, s1_valid_d;
    logic [NGRP-1:0][DATA_W-1:0] s1_dat_q,   s1_dat_d;
    logic [NGRP-1:0][LIDX_W-1:0] s1_lidx_q,  s1_lidx_d;
    logic [NGRP-1:0]             s1_any_q,   s1_any_d;

    logic                        out_valid_q, out_valid_d;
    logic [DATA_W-1:0]           out_dat_q,   out_dat_d;
    logic [IDX_W-1:0]            out_idx_q,   out_idx_d;
    logic                        out_hit_q,   out_hit_d;

    // Stage 2 advances when the output slot is empty or being drained; stage 1
    // advances when it is empty (bubble collapse) or stage 2 advances.
    logic adv1, adv2;

    always_comb begin
        adv2     = !out_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1;
    end

    // Cross-group winner from the stage-1 registers
    logic [DATA_W-1:0] x_dat;
    logic [IDX_W-1:0]  x_idx;
    logic              x_hit;

    always_comb begin
        x_dat = '0;
        x_idx = '0;
        x_hit = 1'b0;
        if (HIGH_FIRST != 0) begin
            for (int g = 0; g < NGRP; g++) begin
                if (s1_any_q[g]) begin
                    x_dat = s1_dat_q[g];
                    x_idx = IDX_W'(g * GROUP + int'(s1_lidx_q[g]));
                    x_hit = 1'b1;
                end
            end
        end else begin
            for (int g = NGRP - 1; g >= 0; g--) begin
                if (s1_any_q[g]) begin
                    x_dat = s1_dat_q[g];
                    x_idx = IDX_W'(g * GROUP + int'(s1_lidx_q[g]));
                    x_hit = 1'b1;
                end
            end
        end
    end

    // Next-state: payload registers only load alongside a valid token
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_dat_d   = s1_dat_q;
        s1_lidx_d  = s1_lidx_q;
        s1_any_d   = s1_any_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_dat_d  = g_dat;
                s1_lidx_d = g_lidx;
                s1_any_d  = g_any;
            end
        end

        out_valid_d = out_valid_q;
        out_dat_d   = out_dat_q;
        out_idx_d   = out_idx_q;
        out_hit_d   = out_hit_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_dat_d = x_dat;
                out_idx_d = x_idx;
                out_hit_d = x_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_dat_q   <= '0;
            out_idx_q   <= '0;
            out_hit_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_dat_q   <= out_dat_d;
            out_idx_q   <= out_idx_d;
            out_hit_q   <= out_hit_d;
        end
    end

    // Stage-1 payload is qualified by s1_valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        s1_dat_q  <= s1_dat_d;
        s1_lidx_q <= s1_lidx_d;
        s1_any_q  <= s1_any_d;
    end

    assign out_valid = out_valid_q;
    assign out_dat   = out_dat_q;
    assign out_idx   = out_idx_q;
    assign out_hit   = out_hit_q;
endmodule

// File: tb/tb_priority_mux_pipe.sv
// Bench for priority_mux_pipe. Three instances share clock, reset and the
// handshake inputs: N=24 high-first, N=24 low-first, and N=10/GROUP=4
// high-first (fed with the low 10 channels). A flat channel-scan reference
// model fills a scoreboard queue on every accepted input.
module tb_priority_mux_pipe;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [23:0]  sel = '0;
    logic [191:0] dat = '0;

    always #5 clk = ~clk;

    logic       hi_in_ready, hi_out_valid, hi_out_hit;
    logic [7:0] hi_out_dat;
    logic [4:0] hi_out_idx;
    logic       lo_in_ready, lo_out_valid, lo_out_hit;
    logic [7:0] lo_out_dat;
    logic [4:0] lo_out_idx;
    logic       od_in_ready, od_out_valid, od_out_hit;
    logic [7:0] od_out_dat;
    logic [3:0] od_out_idx;

    priority_mux_pipe #(.N(24), .DATA_W(8), .GROUP(6), .HIGH_FIRST(1)) u_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(hi_in_ready),
        .sel(sel), .dat(dat), .out_valid(hi_out_valid), .out_ready(out_ready),
        .out_dat(hi_out_dat), .out_idx(hi_out_idx), .out_hit(hi_out_hit));

    priority_mux_pipe #(.N(24), .DATA_W(8), .GROUP(6), .HIGH_FIRST(0)) u_lo (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(lo_in_ready),
        .sel(sel), .dat(dat), .out_valid(lo_out_valid), .out_ready(out_ready),
        .out_dat(lo_out_dat), .out_idx(lo_out_idx), .out_hit(lo_out_hit));

    priority_mux_pipe #(.N(10), .DATA_W(8), .GROUP(4), .HIGH_FIRST(1)) u_od (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(od_in_ready),
        .sel(sel[9:0]), .dat(dat[79:0]), .out_valid(od_out_valid), .out_ready(out_ready),
        .out_dat(od_out_dat), .out_idx(od_out_idx), .out_hit(od_out_hit));

    typedef struct {
        logic [7:0] hd; logic [4:0] hi; logic hh;
        logic [7:0] ld; logic [4:0] li; logic lh;
        logic [7:0] od; logic [3:0] oi; logic oh;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_stall = -1;
    bit   prev_stall = 0;
    logic [7:0] prev_dat;
    logic [4:0] prev_idx;
    logic       prev_hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Flat scan over real channels: high-first keeps the last hit, low-first the first.
    function automatic void pick(input logic [23:0] s, input logic [191:0] d, input int n,
                                 input bit hf, output logic [7:0] od, output logic [4:0] oi,
                                 output logic oh);
        od = '0; oi = '0; oh = 1'b0;
        for (int i = 0; i < n; i++)
            if (s[i] && (hf || !oh)) begin
                od = d[i*8 +: 8];
                oi = 5'(i);
                oh = 1'b1;
            end
    endfunction

    function automatic exp_t model(input logic [23:0] s, input logic [191:0] d);
        exp_t e;
        logic [4:0] t;
        pick(s, d, 24, 1'b1, e.hd, e.hi, e.hh);
        pick(s, d, 24, 1'b0, e.ld, e.li, e.lh);
        pick(s, d, 10, 1'b1, e.od, t, e.oh);
        e.oi  = t[3:0];
        e.acc = 0;
        return e;
    endfunction

    // One clock: check handshake/scoreboard just before the edge, then advance
    // to the next falling edge where the caller drives new inputs.
    task automatic step();
        exp_t e;
        bit fin, fout, stall;
        #1;
        if (!rst) begin
            chk("in_ready",     hi_in_ready, (q.size() < 2) || out_ready);
            chk("lo_in_ready",  lo_in_ready, (q.size() < 2) || out_ready);
            chk("odd_in_ready", od_in_ready, (q.size() < 2) || out_ready);
            chk("no_spurious",  hi_out_valid && (q.size() == 0), 1'b0);
            if (prev_stall) begin
                chk("hold_dat", hi_out_dat, prev_dat);
                chk("hold_idx", hi_out_idx, prev_idx);
                chk("hold_hit", hi_out_hit, prev_hit);
            end
            fin   = in_valid && hi_in_ready;
            fout  = hi_out_valid && out_ready;
            stall = hi_out_valid && !out_ready;
            if (fout && q.size() > 0) begin
                e = q.pop_front();
                chk("hi_dat", hi_out_dat, e.hd);
                chk("hi_idx", hi_out_idx, e.hi);
                chk("hi_hit", hi_out_hit, e.hh);
                chk("lo_valid", lo_out_valid, 1'b1);
                chk("lo_dat", lo_out_dat, e.ld);
                chk("lo_idx", lo_out_idx, e.li);
                chk("lo_hit", lo_out_hit, e.lh);
                chk("odd_valid", od_out_valid, 1'b1);
                chk("odd_dat", od_out_dat, e.od);
                chk("odd_idx", od_out_idx, e.oi);
                chk("odd_hit", od_out_hit, e.oh);
                if (last_stall < e.acc) chk("latency", cyc - e.acc, 2);
            end
            if (stall) last_stall = cyc;
            if (fin) begin
                e = model(sel, dat);
                e.acc = cyc;
                q.push_back(e);
            end
            prev_stall = stall;
            prev_dat   = hi_out_dat;
            prev_idx   = hi_out_idx;
            prev_hit   = hi_out_hit;
        end else begin
            q.delete();
            prev_stall = 0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [23:0] s, input logic [191:0] d);
        sel = s; dat = d; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    function automatic logic [191:0] rnd_dat();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [191:0] d;

        // Reset held two cycles with in_valid high
        rst = 1'b1; in_valid = 1'b1; sel = 24'hFFFFFF; dat = rnd_dat();
        step(); step();
        chk("rst_valid", hi_out_valid, 1'b0);
        chk("rst_dat",   hi_out_dat, 8'h00);
        chk("rst_idx",   hi_out_idx, 5'd0);
        chk("rst_hit",   hi_out_hit, 1'b0);
        chk("rst_odd_valid", od_out_valid, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("rst_in_ready", hi_in_ready, 1'b1);
        step();

        // Basic select, both priorities, two-cycle latency
        out_ready = 1'b1;
        d = rnd_dat();
        d[23*8 +: 8] = 8'hA5; d[6*8 +: 8] = 8'h77; d[5*8 +: 8] = 8'h11; d[0 +: 8] = 8'h3C;
        issue(24'h800061, d);
        chk("b1_valid", hi_out_valid, 1'b1);
        chk("b1_dat", hi_out_dat, 8'hA5);
        chk("b1_idx", hi_out_idx, 5'd23);
        chk("b1_hit", hi_out_hit, 1'b1);
        chk("b1_lo_dat", lo_out_dat, 8'h3C);
        chk("b1_lo_idx", lo_out_idx, 5'd0);
        chk("b1_odd_idx", od_out_idx, 4'd6);
        chk("b1_odd_dat", od_out_dat, 8'h77);
        issue(24'h000060, d);
        chk("b2_dat", hi_out_dat, 8'h77);
        chk("b2_idx", hi_out_idx, 5'd6);
        chk("b2_lo_dat", lo_out_dat, 8'h11);
        chk("b2_lo_idx", lo_out_idx, 5'd5);

        // No hit
        issue(24'h000000, {192{1'b1}});
        chk("nh_valid", hi_out_valid, 1'b1);
        chk("nh_hit", hi_out_hit, 1'b0);
        chk("nh_dat", hi_out_dat, 8'h00);
        chk("nh_idx", hi_out_idx, 5'd0);
        chk("nh_lo_hit", lo_out_hit, 1'b0);
        chk("nh_odd_dat", od_out_dat, 8'h00);
        step();

        // Backpressure: A, B accepted, C blocked until release
        out_ready = 1'b0; in_valid = 1'b1;
        sel = 24'h000008; dat = rnd_dat(); step();
        sel = 24'h010000; dat = rnd_dat(); step();
        sel = 24'h000400; dat = rnd_dat();
        #1 chk("bp_in_ready", hi_in_ready, 1'b0);
        step(); step();
        chk("bp_hold_valid", hi_out_valid, 1'b1);
        chk("bp_hold_idx", hi_out_idx, 5'd3);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_b_idx", hi_out_idx, 5'd16);
        step();
        chk("bp_c_idx", hi_out_idx, 5'd10);
        step();
        chk("bp_empty", hi_out_valid, 1'b0);

        // Bubble collapse
        out_ready = 1'b0;
        sel = 24'h000100; dat = rnd_dat(); in_valid = 1'b1; step();
        in_valid = 1'b0; step();
        sel = 24'h000002; dat = rnd_dat(); in_valid = 1'b1;
        #1 chk("bubble_in_ready", hi_in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bubble_inflight", q.size(), 2);
        out_ready = 1'b1;
        step(); step(); step();

        // Odd width instance
        d = rnd_dat();
        issue(24'h000300, d);
        chk("odd1_idx", od_out_idx, 4'd9);
        chk("odd1_dat", od_out_dat, d[9*8 +: 8]);
        issue(24'h000020, d);
        chk("odd2_idx", od_out_idx, 4'd5);
        chk("odd2_dat", od_out_dat, d[5*8 +: 8]);
        issue(24'h000001, d);
        chk("odd3_idx", od_out_idx, 4'd0);
        chk("odd3_dat", od_out_dat, d[0 +: 8]);
        step();

        // Reset mid-flight
        out_ready = 1'b0; in_valid = 1'b1;
        sel = 24'h000010; dat = rnd_dat(); step();
        sel = 24'h000800; dat = rnd_dat(); step();
        rst = 1'b1; step();
        rst = 1'b0; in_valid = 1'b0;
        chk("mr_valid", hi_out_valid, 1'b0);
        #1 chk("mr_in_ready", hi_in_ready, 1'b1);
        out_ready = 1'b1;
        issue(24'h004000, rnd_dat());
        chk("mr_new_valid", hi_out_valid, 1'b1);
        chk("mr_new_idx", hi_out_idx, 5'd14);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       sel = '0;
                1:       sel = 24'(1) << $urandom_range(0, 23);
                default: sel = 24'($urandom() & $urandom());
            endcase
            dat = rnd_dat();
            step();
        end

        // Drain: everything accepted must come out, bounded
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) step();
        chk("drain_empty", q.size(), 0);
        step();
        chk("drain_valid", hi_out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
